// File: rtl/coriolis_arb_pkg.sv
// Shared constants and tag bundle for the Coriolis FP multiplier arbiter.
// Also provides the default stream width used by requesters.
package coriolis_arb_pkg;

  localparam logic [1:0] FPC_EF = 2'b01;
  localparam int STREAMW_DEF = 34;
  localparam int TAG_IDW = 4;

  typedef struct packed {
    logic               vld;
    logic [TAG_IDW-1:0] id;
  } arb_tag_t;

  localparam int TAG_W = $bits(arb_tag_t);

endpackage

// File: rtl/coriolis_rr_arbiter.sv
// Round-robin grant selection: search starts after the last granted
// requester; pointer advances only when the grant is taken (en_i).
module coriolis_rr_arbiter
  import coriolis_arb_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en_i,
  input  logic [NREQ-1:0]    req_i,
  output logic [NREQ-1:0]    gnt_o,
  output logic [TAG_IDW-1:0] gnt_id_o
);

  logic [TAG_IDW-1:0] ptr_q;
  logic [TAG_IDW-1:0] ptr_d;

  always_comb begin
    int   idx;
    logic found;
    idx      = 0;
    found    = 1'b0;
    gnt_o    = '0;
    gnt_id_o = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_id_o   = TAG_IDW'(idx);
      end
    end
  end

  assign ptr_d = en_i ? gnt_id_o : ptr_q;

  // Reset to the last slot so requester 0 is searched first.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ptr_q <= TAG_IDW'(NREQ - 1);
    else      ptr_q <= ptr_d;
  end

endmodule

// File: rtl/coriolis_fpmul_arbiter.sv
// Shares one pipelined FP multiplier among NREQ requesters.
// Optional per-requester grant counters: CORIOLIS_FPMUL_ARB_STATS_EN.
module coriolis_fpmul_arbiter
  import coriolis_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int STREAMW = STREAMW_DEF,
  parameter int MUL_LAT = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*STREAMW-1:0] req_x,
  input  logic [NREQ*STREAMW-1:0] req_y,
  output logic [NREQ-1:0]         res_valid,
  input  logic [NREQ-1:0]         res_ready,
  output logic [NREQ*STREAMW-1:0] res_data,
  output logic [STREAMW-1:0]      mul_x,
  output logic [STREAMW-1:0]      mul_y,
  output logic                    mul_stall,
  input  logic [STREAMW-1:0]      mul_r
`ifdef CORIOLIS_FPMUL_ARB_STATS_EN
  ,
  output logic [NREQ*16-1:0]      stat_grants
`endif
);

  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    xfer;
  logic [NREQ-1:0]    cap;
  logic [NREQ-1:0]    res_valid_q;
  logic [NREQ-1:0]    res_valid_d;
  logic [TAG_IDW-1:0] gnt_id;
  logic               stall;
  logic               fire;
  logic [STREAMW-1:0] sel_x;
  logic [STREAMW-1:0] sel_y;
  logic [STREAMW-1:0] mul_x_q;
  logic [STREAMW-1:0] mul_y_q;
  logic [STREAMW-1:0] res_q [NREQ];
  arb_tag_t           iss_q;
  arb_tag_t           tail;
  arb_tag_t           tag_q [MUL_LAT];

  coriolis_rr_arbiter #(
    .NREQ(NREQ)
  ) u_rr (
    .clk      (clk),
    .rst      (rst),
    .en_i     (fire),
    .req_i    (req_valid),
    .gnt_o    (gnt),
    .gnt_id_o (gnt_id)
  );

  assign tail = tag_q[MUL_LAT-1];

  // Freeze everything when the tail result has nowhere to go.
  always_comb begin
    stall = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (tail.vld && tail.id == TAG_IDW'(i))
        stall = res_valid_q[i] & ~res_ready[i];
    end
  end

  assign req_ready = gnt & {NREQ{~stall & rst}};
  assign xfer      = req_valid & req_ready;
  assign fire      = |xfer;
  assign mul_stall = stall;
  assign mul_x     = mul_x_q;
  assign mul_y     = mul_y_q;
  assign res_valid = res_valid_q;

  always_comb begin
    sel_x = '0;
    sel_y = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_x = req_x[i*STREAMW +: STREAMW];
        sel_y = req_y[i*STREAMW +: STREAMW];
      end
    end
  end

  // Issue stage sits alongside the operand registers feeding the multiplier.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      iss_q   <= '0;
      mul_x_q <= '0;
      mul_y_q <= '0;
    end else if (!stall) begin
      iss_q <= '{vld: fire, id: gnt_id};
      if (fire) begin
        mul_x_q <= sel_x;
        mul_y_q <= sel_y;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < MUL_LAT; k++) tag_q[k] <= '0;
    end else if (!stall) begin
      tag_q[0] <= iss_q;
      for (int k = 1; k < MUL_LAT; k++) tag_q[k] <= tag_q[k-1];
    end
  end

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      cap[i] = tail.vld && (tail.id == TAG_IDW'(i)) && !stall;
      res_valid_d[i] = cap[i] | (res_valid_q[i] & ~res_ready[i]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_valid_q <= '0;
      for (int i = 0; i < NREQ; i++) res_q[i] <= '0;
    end else begin
      res_valid_q <= res_valid_d;
      for (int i = 0; i < NREQ; i++)
        if (cap[i]) res_q[i] <= mul_r;
    end
  end

  for (genvar g = 0; g < NREQ; g++) begin : g_res
    assign res_data[g*STREAMW +: STREAMW] = res_q[g];
  end

`ifdef CORIOLIS_FPMUL_ARB_STATS_EN
  logic [15:0] cnt_q [NREQ];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREQ; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++)
        if (xfer[i] && cnt_q[i] != 16'hFFFF)
          cnt_q[i] <= cnt_q[i] + 16'd1;
    end
  end

  for (genvar s = 0; s < NREQ; s++) begin : g_stat
    assign stat_grants[s*16 +: 16] = cnt_q[s];
  end
`endif

endmodule

// File: tb/tb_coriolis_fpmul_arbiter.sv
// Bench for coriolis_fpmul_arbiter: stub multiplier, queue model,
// directed scenarios. Define CORIOLIS_FPMUL_ARB_STATS_EN for counters.
module tb_coriolis_fpmul_arbiter;
  import coriolis_arb_pkg::*;

  localparam int N = 4;
  localparam int W = 34;
  localparam int L = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_x;
  logic [N*W-1:0] req_y;
  logic [N-1:0]   res_valid;
  logic [N-1:0]   res_ready;
  logic [N*W-1:0] res_data;
  logic [W-1:0]   mul_x;
  logic [W-1:0]   mul_y;
  logic           mul_stall;
  logic [W-1:0]   mul_r;
`ifdef CORIOLIS_FPMUL_ARB_STATS_EN
  logic [N*16-1:0] stat_grants;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  coriolis_fpmul_arbiter #(
    .NREQ(N), .STREAMW(W), .MUL_LAT(L)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .req_y     (req_y),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .mul_x     (mul_x),
    .mul_y     (mul_y),
    .mul_stall (mul_stall),
    .mul_r     (mul_r)
`ifdef CORIOLIS_FPMUL_ARB_STATS_EN
    ,
    .stat_grants (stat_grants)
`endif
  );

  always #5 clk = ~clk;

  // Normal-number single-precision multiply, truncating.
  function automatic logic [W-1:0] fmul(input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic [47:0] p;
    logic [9:0]  e;
    logic [22:0] m;
    p = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    e = {2'b0, a[30:23]} + {2'b0, b[30:23]} - 10'd127;
    if (p[47]) begin
      m = p[46:24];
      e = e + 10'd1;
    end else begin
      m = p[45:23];
    end
    return {a[33:32], a[31] ^ b[31], e[7:0], m};
  endfunction

  function automatic logic [N-1:0] rr_pick(input logic [N-1:0] v,
                                           input int last);
    logic [N-1:0] r;
    r = '0;
    for (int k = 1; k <= N; k++) begin
      if (r == '0 && v[(last + k) % N]) r[(last + k) % N] = 1'b1;
    end
    return r;
  endfunction

  // Stub multiplier: L stages, frozen by mul_stall.
  logic [W-1:0] mp [L];
  always @(posedge clk) begin
    if (!mul_stall) begin
      mp[0] <= fmul(mul_x, mul_y);
      for (int k = 1; k < L; k++) mp[k] <= mp[k-1];
    end
  end
  assign mul_r = mp[L-1];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Model: per-requester queues of expected products in issue order.
  logic [W-1:0] q [N][$];
  int           last_g = N - 1;
  logic [N-1:0] held = '0;
  logic [W-1:0] held_d [N];

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) q[i].delete();
      last_g = N - 1;
      held   = '0;
    end else begin
      if (mul_stall) begin
        chk("ready_in_stall", req_ready, '0);
        chk("stall_cause", |(res_valid & ~res_ready), 1'b1);
      end else begin
        chk("rr_grant", req_ready, rr_pick(req_valid, last_g));
      end
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          q[i].push_back(fmul(req_x[i*W +: W], req_y[i*W +: W]));
          last_g = i;
        end
      end
      for (int i = 0; i < N; i++) begin
        if (held[i]) begin
          chk("hold_valid", res_valid[i], 1'b1);
          chk("hold_data", res_data[i*W +: W], held_d[i]);
        end
        if (res_valid[i] && q[i].size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_result: req %0d data %h, none owed",
                   i, res_data[i*W +: W]);
        end else if (res_valid[i] && res_ready[i]) begin
          chk("res_data", res_data[i*W +: W], q[i].pop_front());
        end
        held[i]   = res_valid[i] & ~res_ready[i];
        held_d[i] = res_data[i*W +: W];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setop(input int i, input logic [31:0] x,
                       input logic [31:0] y);
    req_x[i*W +: W] = {FPC_EF, x};
    req_y[i*W +: W] = {FPC_EF, y};
  endtask

  task automatic wait_for(input int kind, input int idx, input string nm);
    logic ok;
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      case (kind)
        0:       ok = req_ready[idx];
        1:       ok = res_valid[idx];
        default: ok = mul_stall;
      endcase
      if (ok) break;
    end
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: timed out, event never seen", nm);
  endtask

  int nx;

  initial begin
    rst       = 1'b0;
    req_valid = '1;
    req_x     = '0;
    req_y     = '0;
    res_ready = '1;
    for (int i = 0; i < N; i++) setop(i, 32'h3F800000, 32'h40000000);

    chk("model_1x2", fmul({FPC_EF, 32'h3F800000}, {FPC_EF, 32'h40000000}),
        34'h140000000);
    chk("model_1p5x3", fmul({FPC_EF, 32'h3FC00000}, {FPC_EF, 32'h40400000}),
        34'h140900000);

    @(negedge clk);
    chk("rst_ready", req_ready, '0);
    chk("rst_res_valid", res_valid, '0);
    chk("rst_mul_x", mul_x, '0);
    chk("rst_res_data", res_data, '0);
    chk("rst_stall", mul_stall, 1'b0);
    tick();
    rst       = 1'b1;
    req_valid = '0;

    // Single op: 1.0 * 2.0 on requester 0, latency L+1 edges.
    tick();
    req_valid = 4'b0001;
    @(negedge clk);
    chk("t1_ready", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    for (int k = 0; k <= L; k++) begin
      @(negedge clk);
      chk("t1_not_yet", res_valid[0], 1'b0);
    end
    @(negedge clk);
    chk("t1_valid", res_valid[0], 1'b1);
    chk("t1_data", res_data[0 +: W], 34'h140000000);
    repeat (4) tick();

    // All requesters valid: rotate starting after requester 0.
    for (int i = 0; i < N; i++)
      setop(i, 32'h3F800000 + (i << 23), 32'h40400000);
    req_valid = '1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("rr_seq", req_ready, 4'b0001 << ((k + 1) % N));
      tick();
    end
    req_valid = '0;
    repeat (10) tick();

    // Backpressure on requester 2 stalls the shared pipe.
    res_ready = 4'b1011;
    setop(2, 32'h3FC00000, 32'h40400000);
    req_valid = 4'b0100;
    wait_for(0, 2, "t4_issue_a");
    tick();
    req_valid = '0;
    wait_for(1, 2, "t4_first_result");
    tick();
    setop(2, 32'h40000000, 32'h40400000);
    req_valid = 4'b0100;
    wait_for(0, 2, "t4_issue_b");
    tick();
    req_valid = 4'b0001;
    wait_for(2, 0, "t4_stall");
    chk("t4_ready_zero", req_ready, '0);
    chk("t4_hold_a", res_data[2*W +: W], 34'h140900000);
    repeat (2) begin
      tick();
      @(negedge clk);
      chk("t4_still_stall", mul_stall, 1'b1);
      chk("t4_still_a", res_data[2*W +: W], 34'h140900000);
    end
    tick();
    res_ready = '1;
    req_valid = '0;
    @(negedge clk);
    chk("t4_released", mul_stall, 1'b0);
    @(negedge clk);
    chk("t4_b_valid", res_valid[2], 1'b1);
    chk("t4_b_data", res_data[2*W +: W], 34'h140C00000);
    repeat (12) tick();

    // Back-to-back results on requester 1 with res_ready held high.
    setop(1, 32'h3F800000, 32'hC0000000);
    req_valid = 4'b0010;
    nx = 0;
    for (int c = 0; c < 10 && nx < 2; c++) begin
      @(negedge clk);
      if (req_ready[1]) nx++;
      tick();
      setop(1, 32'h3FC00000, 32'h3FC00000);
    end
    req_valid = '0;
    chk("t5_two_issues", nx, 2);
    wait_for(1, 1, "t5_first");
    chk("t5_first_data", res_data[W +: W], 34'h1C0000000);
    @(negedge clk);
    chk("t5_no_gap", res_valid[1], 1'b1);
    chk("t5_second_data", res_data[W +: W], 34'h140100000);
    repeat (6) tick();

    // Reset with three operations in flight.
    for (int i = 0; i < 3; i++) setop(i, 32'h40000000, 32'h40000000);
    req_valid = 4'b0111;
    repeat (3) begin
      @(negedge clk);
      tick();
    end
    req_valid = '0;
    #2;
    rst       = 1'b0;
    req_valid = '1;
    #1;
    chk("t6_ready", req_ready, '0);
    chk("t6_res_valid", res_valid, '0);
    chk("t6_mul_x", mul_x, '0);
    chk("t6_mul_y", mul_y, '0);
    chk("t6_res_data", res_data, '0);
    chk("t6_stall", mul_stall, 1'b0);
    @(negedge clk);
    tick();
    rst       = 1'b1;
    req_valid = '0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("t6_no_stale", res_valid, '0);
    end
    tick();
    req_valid = '1;
    @(negedge clk);
    chk("t6_ptr_reset", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    repeat (8) tick();

`ifdef CORIOLIS_FPMUL_ARB_STATS_EN
    setop(3, 32'h3F800000, 32'h3F800000);
    req_valid = 4'b1000;
    repeat (70000) tick();
    req_valid = '0;
    repeat (8) tick();
    chk("stat3_sat", stat_grants[3*16 +: 16], 16'hFFFF);
    chk("stat1", stat_grants[16 +: 16], 16'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/coriolis_fpmul_arbiter.md
CORIOLIS_FPMUL_ARBITER -- requirements
Module: coriolis_fpmul_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters sharing one FP multiplier.
REQ-002 SHALL have parameter STREAMW, default 34, operand/result width (2-bit FloPoCo exception field + 32-bit IEEE single).
REQ-003 SHALL have parameter MUL_LAT, default 3, fixed pipeline latency in cycles of the attached multiplier.
REQ-004 SHALL use one clock and an asynchronous, active-low reset, with ports named as below.
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous reset, active-low.
- req_valid  input  NREQ  per-requester operand valid.
- req_ready  output  NREQ  per-requester operand accepted.
- req_x  input  NREQ*STREAMW  packed X operands, requester i at slice i.
- req_y  input  NREQ*STREAMW  packed Y operands.
- res_valid  output  NREQ  per-requester result valid.
- res_ready  input  NREQ  per-requester result consumed.
- res_data  output  NREQ*STREAMW  packed results.
- mul_x  output  STREAMW  X operand to the shared multiplier.
- mul_y  output  STREAMW  Y operand to the shared multiplier.
- mul_stall  output  1  freezes the shared multiplier pipeline.
- mul_r  input  STREAMW  multiplier result.

Function
REQ-005 SHALL grant at most one requester per cycle, round-robin: search starts at the requester after the last granted one.
REQ-006 SHALL drive req_ready[i] = grant[i] & ~stall, combinationally; a transfer occurs only when req_valid[i] & req_ready[i].
REQ-007 SHALL register the granted operands into mul_x/mul_y on the accepting edge, and hold them otherwise.
REQ-008 SHALL track each issue with a tag pipeline of MUL_LAT stages (valid bit + requester id) that advances only when not stalled.
REQ-009 SHALL capture mul_r into requester id's output register when the tag tail is valid and not stalled; res_valid rises MUL_LAT+1 edges after acceptance (4 by default).
REQ-010 SHALL assert stall when the tag tail is valid and its destination has res_valid=1 & res_ready=0; mul_stall = stall.
REQ-011 SHALL, on same-cycle res_ready and a new result for that requester, accept the new result with no bubble.
REQ-012 SHALL pass operand bits through unmodified; no arithmetic or exception-field handling is performed in this block.
REQ-013 SHALL hold res_data[i] stable while res_valid[i]=1 & res_ready[i]=0.
REQ-014 SHALL make no commitment to a requester that drops req_valid before req_ready.

Reset
REQ-015 SHALL, on rst low, immediately clear req_ready, res_valid, all tag valid bits, mul_x, mul_y and res_data to 0, and set the round-robin pointer so requester 0 is searched first.
REQ-016 SHALL discard in-flight operations on mid-operation reset; no res_valid may appear for pre-reset issues.

Configuration
REQ-017 SHALL, with CORIOLIS_FPMUL_ARB_STATS_EN defined, add output stat_grants (NREQ*16 bits): per-requester saturating 16-bit grant counters, cleared by reset.
REQ-018 SHALL, without CORIOLIS_FPMUL_ARB_STATS_EN, omit the port and the counters entirely.

Structure
REQ-019 SHALL take the constants FPC_EF (2'b01), STREAMW default and the tag struct width from shared package coriolis_arb_pkg.
REQ-020 SHALL implement grant selection in sub-module coriolis_rr_arbiter (NREQ-wide request in, one-hot grant out, pointer update on enable).

Verification
REQ-021 SHALL cover: req0 sends X=34'h13F800000 (1.0), Y=34'h140000000 (2.0) -> res_valid[0] rises 4 edges later, res_data[0]=34'h140000000.
REQ-022 SHALL cover: all 4 requesters valid continuously -> grants 0,1,2,3,0,... with one issue every cycle, and no requester starved.
REQ-023 SHALL cover: res_ready[2]=0 while req2 holds an unread result and another req2 result reaches the tail -> mul_stall=1, all req_ready=0, and res_data[2] is unchanged until res_ready[2]=1.
REQ-024 SHALL cover: res_valid[1] and res_ready[1] both high as the next req1 result arrives -> back-to-back res_valid with no gap.
REQ-025 SHALL cover: rst low with 3 operations in flight -> all outputs 0 asynchronously; after release, no res_valid without new requests.
REQ-026 SHALL cover: with CORIOLIS_FPMUL_ARB_STATS_EN, 70000 grants to req3 -> stat_grants slice 3 saturates at 16'hFFFF.
